// File: rtl/color_scan_ctrl.sv
// color_scan_ctrl: filter sequencer and gated edge counter for a TCS3200-style
// colour sensor. Calibration measures per-channel windows against a white
// target; measurement counts sensor edges inside those windows.
module color_scan_ctrl #(
    parameter int CNT_W          = 32,
    parameter int STD_NUM        = 255,
    parameter int SETTLE_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 2**24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cal_req,
    input  logic             start,
    input  logic             sensor_freq,
    output logic [1:0]       filter_select,
    output logic             busy,
    output logic             cal_done,
    output logic             timeout_err,
    output logic [CNT_W-1:0] para_red,
    output logic [CNT_W-1:0] para_green,
    output logic [CNT_W-1:0] para_blue,
    output logic [7:0]       red,
    output logic [7:0]       green,
    output logic [7:0]       blue,
    output logic             result_valid
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SETTLE    = 3'd1,
        S_CAL_ALIGN = 3'd2,
        S_CAL_COUNT = 3'd3,
        S_MEAS      = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    localparam logic [1:0] CH_R = 2'd0;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;

    localparam logic [CNT_W-1:0] ZERO        = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE         = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] STD_LAST    = CNT_W'(STD_NUM - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);

    // Filter-select code for a channel index (red 00, green 11, blue 10).
    function automatic logic [1:0] filter_code(input logic [1:0] ch);
        case (ch)
            CH_R:    filter_code = 2'b00;
            CH_G:    filter_code = 2'b11;
            CH_B:    filter_code = 2'b10;
            default: filter_code = 2'b00;
        endcase
    endfunction

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_ch;
    logic [1:0]       w_ch_next;
    logic             r_mode_cal;

    logic             r_meta;
    logic             r_sync;
    logic             r_sync_d;
    logic             r_ev;

    logic [CNT_W-1:0] r_tmr;
    logic [CNT_W-1:0] r_to;
    logic [CNT_W-1:0] r_win;
    logic [CNT_W-1:0] r_cyc;
    logic [CNT_W-1:0] r_evn;
    logic [7:0]       r_cnt;
    logic [7:0]       r_sh_r;
    logic [7:0]       r_sh_g;

    logic [1:0]       r_filter;
    logic             r_busy;
    logic             r_cal_done;
    logic             r_timeout;
    logic [CNT_W-1:0] r_para_r;
    logic [CNT_W-1:0] r_para_g;
    logic [CNT_W-1:0] r_para_b;
    logic [7:0]       r_red;
    logic [7:0]       r_green;
    logic [7:0]       r_blue;
    logic             r_valid;

    logic             w_accept;
    logic             w_abort;
    logic             w_cal_store;
    logic             w_meas_store;
    logic             w_settle_last;
    logic             w_timeout;
    logic             w_win_last;
    logic [CNT_W-1:0] w_para;
    logic [CNT_W-1:0] w_cyc_inc;
    logic [7:0]       w_cnt_next;

    // Two-flop synchroniser on the sensor input plus registered rising-edge pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
            r_ev     <= 1'b0;
        end else begin
            r_meta   <= sensor_freq;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
            r_ev     <= r_sync & ~r_sync_d;
        end
    end

    // Window length of the channel currently being scanned.
    always_comb begin
        case (r_ch)
            CH_G:    w_para = r_para_g;
            CH_B:    w_para = r_para_b;
            default: w_para = r_para_r;
        endcase
    end

    // Helper terms shared by the sequencer and datapath.
    always_comb begin
        w_settle_last = (r_tmr == SETTLE_LAST);
        w_timeout     = (r_to == TO_LAST) && !r_ev;
        w_win_last    = (w_para == ZERO) || (r_win == (w_para - ONE));
        w_cyc_inc     = (r_cyc == CNT_MAX) ? r_cyc : (r_cyc + ONE);
        if (r_ev && (r_cnt != 8'hFF) && (w_para != ZERO)) begin
            w_cnt_next = r_cnt + 8'd1;
        end else begin
            w_cnt_next = r_cnt;
        end
    end

    // Sequencer next-state and channel-advance logic.
    always_comb begin
        w_state_next = r_state;
        w_ch_next    = r_ch;
        w_accept     = 1'b0;
        w_abort      = 1'b0;
        w_cal_store  = 1'b0;
        w_meas_store = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cal_req || (start && r_cal_done)) begin
                    w_accept     = 1'b1;
                    w_state_next = S_SETTLE;
                    w_ch_next    = CH_R;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (w_settle_last) begin
                    w_state_next = r_mode_cal ? S_CAL_ALIGN : S_MEAS;
                end else begin
                    w_state_next = S_SETTLE;
                end
            end
            S_CAL_ALIGN: begin
                if (r_ev) begin
                    w_state_next = S_CAL_COUNT;
                end else if (w_timeout) begin
                    w_abort      = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_CAL_ALIGN;
                end
            end
            S_CAL_COUNT: begin
                if (r_ev && (r_evn == STD_LAST)) begin
                    w_cal_store = 1'b1;
                    if (r_ch == CH_B) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_SETTLE;
                        w_ch_next    = r_ch + 2'd1;
                    end
                end else if (w_timeout) begin
                    w_abort      = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_CAL_COUNT;
                end
            end
            S_MEAS: begin
                if (w_win_last) begin
                    w_meas_store = 1'b1;
                    if (r_ch == CH_B) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_SETTLE;
                        w_ch_next    = r_ch + 2'd1;
                    end
                end else begin
                    w_state_next = S_MEAS;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, channel and scan-mode registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ch       <= CH_R;
            r_mode_cal <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ch       <= w_ch_next;
            r_mode_cal <= w_accept ? cal_req : r_mode_cal;
        end
    end

    // Settle timer, no-edge timeout counter and measurement window counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmr <= ZERO;
            r_to  <= ZERO;
            r_win <= ZERO;
        end else begin
            r_tmr <= (r_state == S_SETTLE) ? (r_tmr + ONE) : ZERO;
            if (((r_state == S_CAL_ALIGN) || (r_state == S_CAL_COUNT)) && !r_ev && !w_abort) begin
                r_to <= r_to + ONE;
            end else begin
                r_to <= ZERO;
            end
            if ((r_state == S_MEAS) && !w_win_last) begin
                r_win <= r_win + ONE;
            end else begin
                r_win <= ZERO;
            end
        end
    end

    // Calibration cycle counter (saturating) and edge counter after the aligning edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc <= ZERO;
            r_evn <= ZERO;
        end else if (r_state == S_CAL_COUNT) begin
            r_cyc <= w_cyc_inc;
            r_evn <= r_ev ? (r_evn + ONE) : r_evn;
        end else begin
            r_cyc <= ZERO;
            r_evn <= ZERO;
        end
    end

    // Calibration windows, written only when a channel's count completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_para_r <= ZERO;
            r_para_g <= ZERO;
            r_para_b <= ZERO;
        end else if (w_cal_store) begin
            case (r_ch)
                CH_R:    r_para_r <= w_cyc_inc;
                CH_G:    r_para_g <= w_cyc_inc;
                CH_B:    r_para_b <= w_cyc_inc;
                default: r_para_r <= r_para_r;
            endcase
        end else begin
            r_para_r <= r_para_r;
        end
    end

    // Measurement edge counter and per-channel shadow results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= 8'd0;
            r_sh_r <= 8'd0;
            r_sh_g <= 8'd0;
        end else begin
            if ((r_state == S_MEAS) && !w_win_last) begin
                r_cnt <= w_cnt_next;
            end else begin
                r_cnt <= 8'd0;
            end
            if (w_meas_store && (r_ch == CH_R)) begin
                r_sh_r <= w_cnt_next;
            end else begin
                r_sh_r <= r_sh_r;
            end
            if (w_meas_store && (r_ch == CH_G)) begin
                r_sh_g <= w_cnt_next;
            end else begin
                r_sh_g <= r_sh_g;
            end
        end
    end

    // Registered status, filter select and result outputs, aligned to the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filter   <= 2'b00;
            r_busy     <= 1'b0;
            r_cal_done <= 1'b0;
            r_timeout  <= 1'b0;
            r_valid    <= 1'b0;
            r_red      <= 8'd0;
            r_green    <= 8'd0;
            r_blue     <= 8'd0;
        end else begin
            r_filter <= (w_state_next == S_IDLE) ? 2'b00 : filter_code(w_ch_next);
            r_busy   <= (w_state_next != S_IDLE);
            if (w_abort) begin
                r_cal_done <= 1'b0;
            end else if ((w_state_next == S_DONE) && (r_state != S_DONE) && r_mode_cal) begin
                r_cal_done <= 1'b1;
            end else begin
                r_cal_done <= r_cal_done;
            end
            if (w_abort) begin
                r_timeout <= 1'b1;
            end else if (w_accept) begin
                r_timeout <= 1'b0;
            end else begin
                r_timeout <= r_timeout;
            end
            // The blue count finishes in the same cycle DONE is entered, so take it unshadowed.
            if ((w_state_next == S_DONE) && (r_state == S_MEAS)) begin
                r_valid <= 1'b1;
                r_red   <= r_sh_r;
                r_green <= r_sh_g;
                r_blue  <= w_cnt_next;
            end else begin
                r_valid <= 1'b0;
                r_red   <= r_red;
                r_green <= r_green;
                r_blue  <= r_blue;
            end
        end
    end

    assign filter_select = r_filter;
    assign busy          = r_busy;
    assign cal_done      = r_cal_done;
    assign timeout_err   = r_timeout;
    assign para_red      = r_para_r;
    assign para_green    = r_para_g;
    assign para_blue     = r_para_b;
    assign red           = r_red;
    assign green         = r_green;
    assign blue          = r_blue;
    assign result_valid  = r_valid;

endmodule
